ace_snoop_initiator: RTL and testbench

- Interconnect-side initiator for the ACE snoop channels (AC/CR/CD) of one cached master, such as the cache subsystem's snoop port.
- Accepts one snoop command at a time from the coherency controller and issues it on AC.
- Collects the CR response and, when data is transferred, the full cache line on CD.
- Returns the response and the assembled line to the controller over a valid/ready result port.

---
 rtl/ace_snoop_initiator.sv | 181 ++++++++++++++++++
 tb/tb_ace_snoop_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator
//   Interconnect-side initiator for the ACE snoop channels (AC/CR/CD) of one
//   cached master. It takes one snoop command at a time from the coherency
//   controller, issues it on AC, then collects CRRESP and, when data is
//   transferred, the whole line on CD. The response and the assembled line
//   are handed back on a valid/ready result port.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_*                     snoop command from the controller (valid/ready)
//   ac_*                      ACE snoop address channel (master side)
//   cr_*                      ACE snoop response channel
//   cd_*                      ACE snoop data channel
//   rsp_*                     result to the controller (valid/ready)
//   busy_o                    a snoop is in flight (any state but IDLE)
module ace_snoop_initiator #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [3:0]           req_snoop_i,
    input  logic [2:0]           req_prot_i,
    output logic                 ac_valid_o,
    input  logic                 ac_ready_i,
    output logic [AddrWidth-1:0] ac_addr_o,
    output logic [3:0]           ac_snoop_o,
    output logic [2:0]           ac_prot_o,
    input  logic                 cr_valid_i,
    output logic                 cr_ready_o,
    input  logic [4:0]           cr_resp_i,
    input  logic                 cd_valid_i,
    output logic                 cd_ready_o,
    input  logic [DataWidth-1:0] cd_data_i,
    input  logic                 cd_last_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [4:0]           rsp_resp_o,
    output logic [LineWidth-1:0] rsp_line_o,
    output logic                 rsp_err_o,
    output logic                 busy_o
);

    localparam int Beats = LineWidth / DataWidth;
    localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

    typedef enum logic [1:0] {IDLE, AC, COLLECT, RESP} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           snoop_q;
    logic [2:0]           prot_q;
    logic [4:0]           resp_q;
    logic [LineWidth-1:0] line_q;
    logic [CntW-1:0]      beat_cnt_q;
    logic                 cr_done_q, cd_done_q, err_q;

    logic req_hs, cr_hs, cd_hs, is_last_beat, any_beat;
    logic cr_done_d, cd_done_d, dt_d, collect_done;

    assign req_hs       = (state_q == IDLE) && req_valid_i;
    assign cr_hs        = (state_q == COLLECT) && !cr_done_q && cr_valid_i;
    assign cd_hs        = (state_q == COLLECT) && !cd_done_q && cd_valid_i;
    assign is_last_beat = (beat_cnt_q == LastBeat);
    // A beat counts as seen if one was taken earlier (counter moved or line
    // already closed) or one is being taken right now.
    assign any_beat     = cd_done_q || (beat_cnt_q != '0) || cd_hs;

    // Completion looks at this cycle's handshakes too, so a CR and final CD
    // beat landing together still reach RESP on the very next cycle.
    assign cr_done_d    = cr_done_q || cr_hs;
    assign cd_done_d    = cd_done_q || (cd_hs && (cd_last_i || is_last_beat));
    assign dt_d         = cr_hs ? cr_resp_i[0] : resp_q[0];
    assign collect_done = cr_done_d && (!dt_d || cd_done_d);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid_i)  state_d = AC;
            AC:      if (ac_ready_i)   state_d = COLLECT;
            COLLECT: if (collect_done) state_d = RESP;
            RESP:    if (rsp_ready_i)  state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready_o = 1'b0;
        ac_valid_o  = 1'b0;
        ac_addr_o   = '0;
        ac_snoop_o  = '0;
        ac_prot_o   = '0;
        cr_ready_o  = 1'b0;
        cd_ready_o  = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_resp_o  = '0;
        rsp_line_o  = '0;
        rsp_err_o   = 1'b0;
        busy_o      = 1'b1;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            AC: begin
                ac_valid_o = 1'b1;
                ac_addr_o  = addr_q;
                ac_snoop_o = snoop_q;
                ac_prot_o  = prot_q;
            end
            COLLECT: begin
                cr_ready_o = !cr_done_q;
                cd_ready_o = !cd_done_q;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                rsp_resp_o  = resp_q;
                // No data transfer means no line, whatever CD may have sent.
                rsp_line_o  = resp_q[0] ? line_q : '0;
                rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

    // Command capture, response/line collection and error tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            snoop_q    <= '0;
            prot_q     <= '0;
            resp_q     <= '0;
            line_q     <= '0;
            beat_cnt_q <= '0;
            cr_done_q  <= 1'b0;
            cd_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (req_hs) begin
                addr_q     <= req_addr_i;
                snoop_q    <= req_snoop_i;
                prot_q     <= req_prot_i;
                resp_q     <= '0;
                line_q     <= '0;
                beat_cnt_q <= '0;
                cr_done_q  <= 1'b0;
                cd_done_q  <= 1'b0;
                err_q      <= 1'b0;
            end
            if (cr_hs) begin
                resp_q    <= cr_resp_i;
                cr_done_q <= 1'b1;
                // Data was offered but the snooped master says it sent none.
                if (!cr_resp_i[0] && any_beat) err_q <= 1'b1;
            end
            if (cd_hs) begin
                for (int b = 0; b < Beats; b++) begin
                    if (beat_cnt_q == CntW'(b)) line_q[b*DataWidth +: DataWidth] <= cd_data_i;
                end
                if (cd_last_i != is_last_beat) err_q <= 1'b1;
                if (cd_last_i || is_last_beat) cd_done_q <= 1'b1;
                // Counter parks on the last slice instead of wrapping.
                if (!is_last_beat) beat_cnt_q <= beat_cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ace_snoop_initiator.sv
module tb_ace_snoop_initiator;
    localparam int AW = 64, DW = 64, LW = 128, BEATS = LW / DW;

    logic          clk_i = 1'b0, rst_ni = 1'b0;
    logic          req_valid_i = 0, req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [3:0]    req_snoop_i = '0;
    logic [2:0]    req_prot_i = '0;
    logic          ac_valid_o, ac_ready_i = 0;
    logic [AW-1:0] ac_addr_o;
    logic [3:0]    ac_snoop_o;
    logic [2:0]    ac_prot_o;
    logic          cr_valid_i = 0, cr_ready_o;
    logic [4:0]    cr_resp_i = '0;
    logic          cd_valid_i = 0, cd_ready_o;
    logic [DW-1:0] cd_data_i = '0;
    logic          cd_last_i = 0;
    logic          rsp_valid_o, rsp_ready_i = 0;
    logic [4:0]    rsp_resp_o;
    logic [LW-1:0] rsp_line_o;
    logic          rsp_err_o, busy_o;

    always #5 clk_i = ~clk_i;

    ace_snoop_initiator #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_snoop_i(req_snoop_i), .req_prot_i(req_prot_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
        .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i),
        .cd_last_i(cd_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_resp_o(rsp_resp_o),
        .rsp_line_o(rsp_line_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    // One snoop as the bench plans it. mode: 0 random CR timing,
    // 1 CR after all CD beats, 2 CR together with the final beat, 3 CR first.
    typedef struct {
        logic [AW-1:0]                addr;
        logic [3:0]                   snoop;
        logic [2:0]                   prot;
        int                           ac_dly;
        logic [4:0]                   resp;
        int                           nb;
        logic [BEATS-1:0][DW-1:0]     data;
        logic [BEATS-1:0]             last;
        int                           mode;
        int                           hold;
        int                           rst_cyc;
    } txn_t;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    // Expected output values for the current cycle
    logic          exp_req_ready, exp_busy, exp_ac_valid, exp_cr_ready, exp_cd_ready;
    logic          exp_rsp_valid, exp_err;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_snoop;
    logic [2:0]    exp_prot;
    logic [4:0]    exp_resp;
    logic [LW-1:0] exp_line;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_exp_idle();
        exp_req_ready = 1; exp_busy = 0; exp_ac_valid = 0; exp_cr_ready = 0;
        exp_cd_ready = 0; exp_rsp_valid = 0; exp_err = 0;
        exp_addr = '0; exp_snoop = '0; exp_prot = '0; exp_resp = '0; exp_line = '0;
    endtask

    task automatic set_exp_busy();
        set_exp_idle();
        exp_req_ready = 0; exp_busy = 1;
    endtask

    // The single compare process: every cycle, DUT outputs vs. expectations.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("req_ready", req_ready_o, exp_req_ready);
            check("busy", busy_o, exp_busy);
            check("ac_valid", ac_valid_o, exp_ac_valid);
            check("cr_ready", cr_ready_o, exp_cr_ready);
            check("cd_ready", cd_ready_o, exp_cd_ready);
            check("rsp_valid", rsp_valid_o, exp_rsp_valid);
            if (exp_ac_valid) begin
                check("ac_addr", ac_addr_o, exp_addr);
                check("ac_snoop", ac_snoop_o, exp_snoop);
                check("ac_prot", ac_prot_o, exp_prot);
            end
            if (exp_rsp_valid) begin
                check("rsp_resp", rsp_resp_o, exp_resp);
                check("rsp_line", rsp_line_o, exp_line);
                check("rsp_err", rsp_err_o, exp_err);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ac_valid", ac_valid_o, 1'b0);
        check("rst_ac_addr", ac_addr_o, '0);
        check("rst_ac_snoop", ac_snoop_o, '0);
        check("rst_ac_prot", ac_prot_o, '0);
        check("rst_cr_ready", cr_ready_o, 1'b0);
        check("rst_cd_ready", cd_ready_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rsp_resp", rsp_resp_o, '0);
        check("rst_rsp_line", rsp_line_o, '0);
        check("rst_rsp_err", rsp_err_o, 1'b0);
    endtask

    task automatic clear_inputs();
        req_valid_i = 0; ac_ready_i = 0; cr_valid_i = 0; cd_valid_i = 0;
        cd_last_i = 0; rsp_ready_i = 0;
    endtask

    // Drives one snoop end to end and returns what the model says the result is.
    task automatic run_snoop(input txn_t t, input bit rnd,
                             output logic [4:0] m_resp, output logic [LW-1:0] m_line,
                             output bit m_err);
        logic [LW-1:0] line;
        logic [4:0]    resp;
        bit            err, cr_got, cd_cmp, fin, cdv, crv;
        int            bi, sent, cyc, si;
        line = '0; resp = '0; err = 0; cr_got = 0; cd_cmp = 0; fin = 0;
        bi = 0; sent = 0; cyc = 0;
        m_resp = '0; m_line = '0; m_err = 0;

        // IDLE: present command
        req_valid_i = 1; req_addr_i = t.addr; req_snoop_i = t.snoop; req_prot_i = t.prot;
        set_exp_idle();
        @(posedge clk_i); #1;
        req_valid_i = 0; req_addr_i = AW'({$urandom, $urandom});

        // AC: valid from the next cycle, fields stable until ready
        for (int i = 0; i <= t.ac_dly; i++) begin
            ac_ready_i = (i == t.ac_dly);
            set_exp_busy();
            exp_ac_valid = 1; exp_addr = t.addr; exp_snoop = t.snoop; exp_prot = t.prot;
            @(posedge clk_i); #1;
        end
        ac_ready_i = 0;

        // COLLECT
        while (!fin) begin
            if (cyc == t.rst_cyc) begin
                #2;
                rst_ni = 0;
                clear_inputs();
                set_exp_idle();
                #1;
                check_reset_outputs();
                @(posedge clk_i); #1;
                rst_ni = 1;
                return;
            end
            cdv = !cd_cmp && sent < t.nb && (t.mode != 3 || cr_got) && (!rnd || $urandom_range(1) == 0);
            case (t.mode)
                1:       crv = sent >= t.nb;
                2:       crv = cdv && sent == t.nb - 1;
                3:       crv = 1;
                default: crv = (t.resp[0] || sent >= t.nb) && (!rnd || $urandom_range(2) == 0);
            endcase
            crv = crv && !cr_got;
            si  = (sent < BEATS) ? sent : 0;
            cd_valid_i = cdv;
            cd_data_i  = cdv ? t.data[si] : DW'({$urandom, $urandom});
            cd_last_i  = cdv ? t.last[si] : 1'($urandom);
            cr_valid_i = crv;
            cr_resp_i  = crv ? t.resp : 5'($urandom);
            set_exp_busy();
            exp_cr_ready = !cr_got;
            exp_cd_ready = !cd_cmp;
            @(posedge clk_i); #1;
            if (cdv) begin
                line[bi*DW +: DW] = t.data[si];
                if (t.last[si] != (bi == BEATS - 1)) err = 1;
                if (t.last[si] || bi == BEATS - 1) cd_cmp = 1;
                else bi++;
                sent++;
            end
            if (crv) begin
                resp = t.resp;
                cr_got = 1;
                if (!resp[0] && sent > 0) err = 1;
            end
            fin = cr_got && (!resp[0] || cd_cmp);
            cyc++;
            if (!fin && cyc > 200) begin
                check("collect_timeout", 1'b0, 1'b1);
                rst_ni = 0; clear_inputs(); set_exp_idle();
                @(posedge clk_i); #1; rst_ni = 1;
                return;
            end
        end
        cd_valid_i = 0; cr_valid_i = 0;

        m_resp = resp;
        m_line = resp[0] ? line : '0;
        m_err  = err;

        // RESP: held stable while the controller stalls
        for (int i = 0; i <= t.hold; i++) begin
            rsp_ready_i = (i == t.hold);
            set_exp_busy();
            exp_rsp_valid = 1; exp_resp = m_resp; exp_line = m_line; exp_err = m_err;
            @(posedge clk_i); #1;
        end
        rsp_ready_i = 0;
        set_exp_idle();
    endtask

    function automatic txn_t mk(input logic [AW-1:0] addr, input logic [3:0] snoop,
                                input int ac_dly, input logic [4:0] resp, input int nb,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [1:0] last, input int mode, input int hold);
        txn_t t;
        t.addr = addr; t.snoop = snoop; t.prot = 3'b010; t.ac_dly = ac_dly;
        t.resp = resp; t.nb = nb; t.data[0] = d0; t.data[1] = d1; t.last = last;
        t.mode = mode; t.hold = hold; t.rst_cyc = -1;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   kind;
        t.addr = AW'({$urandom, $urandom}); t.snoop = 4'($urandom); t.prot = 3'($urandom);
        t.ac_dly = $urandom_range(3); t.hold = $urandom_range(3); t.rst_cyc = -1;
        t.data[0] = DW'({$urandom, $urandom}); t.data[1] = DW'({$urandom, $urandom});
        if ($urandom_range(2) != 0) begin
            t.resp = {4'($urandom), 1'b1};
            kind = $urandom_range(3);
            if (kind == 0)      begin t.nb = 1; t.last = 2'b01; end   // early last
            else if (kind == 1) begin t.nb = 2; t.last = 2'b00; end   // missing last
            else                begin t.nb = 2; t.last = 2'b10; end
            t.mode = $urandom_range(3);
        end else begin
            t.resp = {4'($urandom), 1'b0};
            t.nb = ($urandom_range(3) == 0) ? 1 : 0;
            t.last = 2'b00;
            t.mode = (t.nb == 0 && $urandom_range(1) == 1) ? 3 : 0;
        end
        return t;
    endfunction

    initial begin
        txn_t          t;
        logic [4:0]    r;
        logic [LW-1:0] l;
        bit            e;
        set_exp_idle();
        clear_inputs();
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs();
        rst_ni = 1;
        chk_en = 1;
        @(posedge clk_i); #1;

        // ReadShared, AC stalled, CR first then two beats
        t = mk(64'h8000_0040, 4'b0001, 2, 5'b01001, 2, 64'h1111, 64'h2222, 2'b10, 3, 0);
        run_snoop(t, 0, r, l, e);
        check("pin_rs_resp", r, 5'h09);
        check("pin_rs_line", l, 128'h0000_0000_0000_2222_0000_0000_0000_1111);
        check("pin_rs_err", e, 1'b0);

        // CleanInvalid, no data
        t = mk(64'h1234_5680, 4'b1001, 0, 5'b00000, 0, 64'hdead, 64'hbeef, 2'b00, 3, 0);
        run_snoop(t, 0, r, l, e);
        check("pin_ci_line", l, '0);
        check("pin_ci_err", e, 1'b0);

        // CD beats before CR, result stalled for 5 cycles
        t = mk(64'h40, 4'b0111, 1, 5'b00101, 2, 64'hA5A5, 64'h5A5A, 2'b10, 1, 5);
        run_snoop(t, 0, r, l, e);
        check("pin_cdfirst_resp", r, 5'h05);
        check("pin_cdfirst_line", l, 128'h0000_0000_0000_5A5A_0000_0000_0000_A5A5);
        check("pin_cdfirst_err", e, 1'b0);

        // CR and final beat in the same cycle
        t = mk(64'h80, 4'b0010, 0, 5'b00001, 2, 64'h33, 64'h44, 2'b10, 2, 0);
        run_snoop(t, 0, r, l, e);
        check("pin_same_line", l, 128'h0000_0000_0000_0044_0000_0000_0000_0033);

        // cd_last on beat 0
        t = mk(64'hC0, 4'b0001, 0, 5'b00001, 1, 64'h77, 64'h88, 2'b01, 1, 0);
        run_snoop(t, 0, r, l, e);
        check("pin_early_err", e, 1'b1);
        check("pin_early_line", l, 128'h77);

        // Reset during COLLECT, then a normal snoop
        t = mk(64'h100, 4'b0001, 0, 5'b00001, 2, 64'h1, 64'h2, 2'b10, 1, 0);
        t.rst_cyc = 1;
        run_snoop(t, 0, r, l, e);
        t = mk(64'h140, 4'b0001, 1, 5'b01001, 2, 64'h9, 64'hA, 2'b10, 0, 1);
        run_snoop(t, 0, r, l, e);
        check("pin_after_rst_line", l, 128'h0000_0000_0000_000A_0000_0000_0000_0009);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            t = rand_txn();
            run_snoop(t, 1, r, l, e);
            repeat ($urandom_range(2)) @(posedge clk_i);
            #1;
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
